ram_master: RTL and testbench
=============================

# ram_master

Bus initiator that drives the single-port synchronous RAM bus (addr / bidirectional data / cs / we / oe) on behalf of a client with a valid/ready request port. It buffers client requests and sequences them onto the RAM pins with the RAM's timing: writes commit on posedge, read data launches on negedge. It captures read data and returns it on a one-cycle response strobe. The block sits between the CPU/datapath load-store unit and the RAM instance.

## Interface
- ADDR_WIDTH, 24, RAM word-address width
- DATA_WIDTH, 16, RAM word width
- FIFO_DEPTH, 4, request buffer depth (power of two ≥2; used only with the FIFO macro)

- clk  input  1  system clock; all state on posedge
- rst_n  input  1  asynchronous, active-low reset
- req_valid  input  1  client request present
- req_ready  output  1  buffer can accept; transfer on valid&ready at posedge
- req_we  input  1  1 = write, 0 = read
- req_addr  input  ADDR_WIDTH  word address
- req_wdata  input  DATA_WIDTH  write data (ignored for reads)
- rsp_valid  output  1  one-cycle read-data strobe; no backpressure
- rsp_rdata  output  DATA_WIDTH  read data, valid while rsp_valid
- idle  output  1  FSM in IDLE and buffer empty
- mem_addr  output  ADDR_WIDTH  RAM address
- mem_data  inout  DATA_WIDTH  RAM data; driven only in WR, else 'z
- mem_cs  output  1  RAM chip select
- mem_we  output  1  RAM write enable
- mem_oe  output  1  RAM output enable

## Operation
- All mem_* outputs and the data drive-enable are registered and change only on posedge.
- Request buffer: entry = {we, addr, wdata}; pushed on req_valid&req_ready; popped when the FSM launches a bus command.
- req_ready = !full, held 0 while rst_n low.
- FSM states: IDLE, RD, WR, TA.
  - IDLE: cs=we=oe=0, no drive. Buffer non-empty → pop; head write → WR, head read → RD.
  - WR (1 cycle): cs=1, we=1, oe=0, mem_data driven with wdata. The RAM commits on the posedge leaving WR. Next state: head write → WR, head read → RD, empty → IDLE.
  - RD (1 cycle): cs=1, we=0, oe=1, no drive. The RAM loads at mid-cycle negedge and drives the bus. mem_data is sampled into rsp_rdata on the posedge leaving RD, and rsp_valid=1 for the next cycle. Next state: head read → RD, head write → TA, empty → IDLE.
  - TA (1 cycle): cs=oe=0, no drive (bus turnaround, prevents contention). Next state: WR.
- Responses return in request order. Writes produce no response.
- Simultaneous push and pop of the same buffer is legal in the same cycle. Occupancy is unchanged when push and pop coincide.
- mem_addr holds its last value in IDLE/TA.

## Timing
- Reset values: req_ready=0 during reset, 1 after; rsp_valid=0; rsp_rdata=0; idle=1; mem_addr=0; mem_cs=mem_we=mem_oe=0; mem_data released ('z); state IDLE; buffer empty.
- A read accepted at posedge k from an idle block:
  - RD occupies cycle k+1..k+2.
  - rsp_valid is high in cycle k+2..k+3 with the data.
  - Latency is 2 cycles, accept to strobe.
- A write accepted at posedge k occupies WR in k+1..k+2. It is visible to a read launched in the next cycle.
- Write after read costs 1 extra cycle (TA). Read after write and same-type runs have no gap.
- Reset asserted mid-operation:
  - Bus is released and cs/we/oe are cleared immediately (asynchronous).
  - Buffered requests are discarded.
  - No rsp_valid is issued for an in-flight read.

## Configuration
- RAM_MASTER_REQ_FIFO_EN defined:
  - The buffer is a FIFO_DEPTH-entry circular FIFO with wrapping pointers and a count.
  - Sustains one request per cycle.
  - req_ready falls only when count == FIFO_DEPTH.
- RAM_MASTER_REQ_FIFO_EN undefined:
  - The buffer is a single holding register and FIFO_DEPTH is ignored.
  - req_ready=0 in the cycle after an accept, so throughput is one request per 2 cycles.
  - Latency is identical.

## Test plan
- After reset, write 0x000010←0xBEEF, then read 0x000010 → exactly one mem_we pulse with mem_data=0xBEEF; rsp_valid exactly 2 cycles after the read accept; rsp_rdata=0xBEEF.
- Read 0x000020 immediately followed by write 0x000020←0x1234 → one TA cycle with cs=0 and mem_data='z between RD and WR; a subsequent read returns 0x1234.
- With the macro, hold req_valid for 6 back-to-back reads while the FSM is held busy behind writes → req_ready drops at count=4; all responses return in order with correct data.
- Without the macro, req_valid held high for 4 writes → req_ready alternates 1/0; writes issue every 2 cycles.
- Assert rst_n low in the RD cycle → mem_cs/mem_oe drop immediately, no rsp_valid, idle=1; the buffer is empty after release.
- Read-after-write to the same address at full rate → no idle cycle between WR and RD; new data returned.

Source files
------------

// File: rtl/ram_master.sv
// ram_master: sequences buffered client requests onto a single-port synchronous RAM bus.
// Define RAM_MASTER_REQ_FIFO_EN for a FIFO_DEPTH-entry request FIFO; otherwise one holding register.
module ram_master #(
    parameter int ADDR_WIDTH = 24,
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  idle,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    inout  wire  [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic                  mem_oe
);
    localparam int ENTRY_W = 1 + ADDR_WIDTH + DATA_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_TA} state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_cs_d;
    logic                  w_we_d;
    logic                  w_oe_d;
    logic [ENTRY_W-1:0]    w_entry;
    logic [ENTRY_W-1:0]    w_head;
    logic                  w_head_we;
    logic [ADDR_WIDTH-1:0] w_head_addr;
    logic [DATA_WIDTH-1:0] w_head_wdata;
    logic                  r_cs;
    logic                  r_we;
    logic                  r_oe;
    logic                  r_drive;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rdata;

    // Ready is forced low while reset is held so nothing is accepted into a clearing buffer.
    assign req_ready = rst_n & ~w_full;
    assign w_push    = req_valid & req_ready;
    assign w_entry   = {req_we, req_addr, req_wdata};
    assign {w_head_we, w_head_addr, w_head_wdata} = w_head;

`ifdef RAM_MASTER_REQ_FIFO_EN
    localparam int              PW       = $clog2(FIFO_DEPTH);
    localparam logic [PW:0]     FULL_CNT = (PW + 1)'(FIFO_DEPTH);

    logic [ENTRY_W-1:0] r_fifo [FIFO_DEPTH];
    logic [PW-1:0]      r_wr_ptr;
    logic [PW-1:0]      r_rd_ptr;
    logic [PW:0]        r_count;

    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);
    assign w_head  = r_fifo[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wr_ptr] <= w_entry;
    end
`else
    logic               r_hold_valid;
    logic [ENTRY_W-1:0] r_hold;

    assign w_full  = r_hold_valid;
    assign w_empty = ~r_hold_valid;
    assign w_head  = r_hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_valid <= 1'b0;
            r_hold       <= '0;
        end else if (w_push) begin
            r_hold_valid <= 1'b1;
            r_hold       <= w_entry;
        end else if (w_pop) begin
            r_hold_valid <= 1'b0;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // A write behind a read detours through TA so the RAM releases the bus first.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (!w_empty) w_next = w_head_we ? S_WR : S_RD;
            S_WR:    w_next = w_empty ? S_IDLE : (w_head_we ? S_WR : S_RD);
            S_RD:    w_next = w_empty ? S_IDLE : (w_head_we ? S_TA : S_RD);
            S_TA:    w_next = S_WR;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_pop  = (w_next == S_RD) || (w_next == S_WR);
        w_cs_d = w_pop;
        w_we_d = (w_next == S_WR);
        w_oe_d = (w_next == S_RD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cs        <= 1'b0;
            r_we        <= 1'b0;
            r_oe        <= 1'b0;
            r_drive     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rsp_valid <= 1'b0;
            r_rdata     <= '0;
        end else begin
            r_cs        <= w_cs_d;
            r_we        <= w_we_d;
            r_oe        <= w_oe_d;
            r_drive     <= w_we_d;
            if (w_pop)  r_addr  <= w_head_addr;
            if (w_we_d) r_wdata <= w_head_wdata;
            // The RAM drove the bus since mid-cycle; capture it as RD ends.
            r_rsp_valid <= (r_state == S_RD);
            if (r_state == S_RD) r_rdata <= mem_data;
        end
    end

    assign mem_cs    = r_cs;
    assign mem_we    = r_we;
    assign mem_oe    = r_oe;
    assign mem_addr  = r_addr;
    assign mem_data  = r_drive ? r_wdata : {DATA_WIDTH{1'bz}};
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rdata;
    assign idle      = (r_state == S_IDLE) && w_empty;

endmodule

// File: tb/tb_ram_master.sv
// Directed bench for ram_master: bus-level RAM model, schedule-based reference model, literal checks.
module tb_ram_master;
  localparam int AW = 24;
  localparam int DW = 16;
`ifdef RAM_MASTER_REQ_FIFO_EN
  localparam int CAP     = 4;
  localparam int ACC_GAP = 1;
`else
  localparam int CAP     = 1;
  localparam int ACC_GAP = 2;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid, req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          req_ready, rsp_valid, idle, mem_cs, mem_we, mem_oe;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] mem_addr;
  wire  [DW-1:0] mem_data;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  ram_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .idle(idle),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_cs(mem_cs),
    .mem_we(mem_we), .mem_oe(mem_oe)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- RAM on the bus ----------------
  logic [DW-1:0] ram_mem [int];
  logic [DW-1:0] ram_q = '0;
  logic          ram_drive = 1'b0;
  int            we_pulses = 0;
  assign mem_data = ram_drive ? ram_q : {DW{1'bz}};

  always @(posedge clk) begin
    if (mem_cs && mem_we) begin
      ram_mem[int'(mem_addr)] = mem_data;
      we_pulses++;
    end
  end

  always @(clk) begin
    if (clk) ram_drive <= 1'b0;
    else if (mem_cs && mem_oe && !mem_we) begin
      ram_q     <= ram_mem.exists(int'(mem_addr)) ? ram_mem[int'(mem_addr)] : '0;
      ram_drive <= 1'b1;
    end
  end

  // ---------------- monitors ----------------
  logic [DW-1:0] seen_rdata = '0;
  int            rsp_count = 0;
  int            stall_cycles = 0;
  always @(posedge clk) begin
    #1;
    if (rsp_valid) begin
      seen_rdata = rsp_rdata;
      rsp_count++;
    end
  end
  always @(negedge clk) if (rst_n && req_valid && !req_ready) stall_cycles++;

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_released(input string nm);
    n_cmp++;
    if (!($isunknown(mem_data) || mem_data == '0)) begin
      n_err++;
      $display("FAIL %s: mem_data actual=%0h required=released (cycle %0d)", nm, mem_data, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // Each accepted request gets a launch posedge: one after acceptance, one after the previous
  // launch, plus one turnaround cycle when a write follows a read.
  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            l;
  } req_t;

  req_t          pend_q[$];
  logic [DW-1:0] exp_q[$];
  int            exp_t_q[$];
  logic [DW-1:0] ref_mem [int];
  int            last_l = -10;
  logic          last_we = 1'b1;
  logic          cur_v = 1'b0, cur_we = 1'b0, rsp_now = 1'b0;
  logic [AW-1:0] cur_addr = '0;
  logic [DW-1:0] cur_wdata = '0, last_rdata = '0;

  task automatic model_clear();
    pend_q.delete(); exp_q.delete(); exp_t_q.delete();
    last_l = -10; last_we = 1'b1;
    cur_v = 1'b0; cur_we = 1'b0; rsp_now = 1'b0;
    cur_addr = '0; cur_wdata = '0; last_rdata = '0;
  endtask

  task automatic model_step();
    int   t, g, l;
    req_t r;
    t = cyc + 1;
    if (req_valid && pend_q.size() < CAP) begin
      g = (!last_we && req_we) ? 1 : 0;
      l = (t + 1 > last_l + 1 + g) ? t + 1 : last_l + 1 + g;
      r.we = req_we; r.addr = req_addr; r.wdata = req_wdata; r.l = l;
      pend_q.push_back(r);
      last_l = l; last_we = req_we;
    end
    cur_v = 1'b0;
    if (pend_q.size() > 0 && pend_q[0].l == t) begin
      r = pend_q.pop_front();
      cur_v = 1'b1; cur_we = r.we; cur_addr = r.addr; cur_wdata = r.wdata;
      if (r.we) ref_mem[int'(r.addr)] = r.wdata;
      else begin
        exp_q.push_back(ref_mem.exists(int'(r.addr)) ? ref_mem[int'(r.addr)] : '0);
        exp_t_q.push_back(t + 1);
      end
    end
    rsp_now = 1'b0;
    if (exp_t_q.size() > 0 && exp_t_q[0] == t) begin
      rsp_now = 1'b1;
      last_rdata = exp_q.pop_front();
      void'(exp_t_q.pop_front());
    end
  endtask

  task automatic model_compare();
    chk("ready", req_ready, rst_n && (pend_q.size() < CAP));
    chk("cs", mem_cs, cur_v);
    chk("we", mem_we, cur_v && cur_we);
    chk("oe", mem_oe, cur_v && !cur_we);
    chk("addr", mem_addr, cur_addr);
    chk("idle", idle, !cur_v && (pend_q.size() == 0));
    chk("rsp_valid", rsp_valid, rsp_now);
    if (rsp_now || !rst_n) chk("rsp_rdata", rsp_rdata, last_rdata);
    if (cur_v && cur_we) chk("wdata_bus", mem_data, cur_wdata);
    else chk_released("bus_released");
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_clear();
    else model_step();
    #1;
    model_compare();
  end

  // ---------------- driver tasks ----------------
  int acc_cyc = 0;

  task automatic send(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n;
    n = 0;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    #1;
    while (!req_ready && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    if (n >= 50) begin
      n_cmp++; n_err++;
      $display("FAIL send_timeout: actual=not accepted required=accepted (cycle %0d)", cyc);
    end
    acc_cyc = cyc + 1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) begin
      @(posedge clk); #2;
    end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int k, b, w_acc, p0, r0, s0;
    int acc[4];
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_idle", idle, 1);
    chk("rst_cs", mem_cs, 0);
    chk("rst_rdata", rsp_rdata, 0);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("ready_after_rst", req_ready, 1);
    @(negedge clk);

    // write then read back, exact response latency
    p0 = we_pulses;
    send(1'b1, 24'h000010, 16'hBEEF);
    send(1'b0, 24'h000010, 16'h0);
    req_valid = 1'b0;
    k = acc_cyc;
    wait_to(k + 1); chk("t1_no_early_rsp", rsp_valid, 0);
    wait_to(k + 2); chk("t1_rsp_valid", rsp_valid, 1); chk("t1_rdata", rsp_rdata, 16'hBEEF);
    wait_to(k + 3); chk("t1_rsp_one_cycle", rsp_valid, 0); chk("t1_we_pulses", we_pulses - p0, 1);

    // read then write same address: turnaround cycle between RD and WR
    send(1'b0, 24'h000020, 16'h0);
    k = acc_cyc;
    send(1'b1, 24'h000020, 16'h1234);
    req_valid = 1'b0;
    wait_to(k + 2);
    chk("t2_ta_cs", mem_cs, 0);
    chk_released("t2_ta_bus");
    wait_to(k + 3);
    chk("t2_wr_we", mem_we, 1);
    chk("t2_wr_data", mem_data, 16'h1234);
    send(1'b0, 24'h000020, 16'h0);
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("t2_readback", seen_rdata, 16'h1234);

    // four writes with valid held: acceptance spacing shows the buffer throughput
    p0 = we_pulses;
    for (int i = 0; i < 4; i++) begin
      send(1'b1, 24'h000040 + 24'(i), 16'hA000 + 16'(i));
      acc[i] = acc_cyc;
    end
    req_valid = 1'b0;
    for (int i = 1; i < 4; i++) chk("t4_acc_gap", acc[i] - acc[i-1], ACC_GAP);
    repeat (4) @(negedge clk);
    chk("t4_we_pulses", we_pulses - p0, 4);

    // alternating read/write fills the buffer; then six back-to-back reads in order
    s0 = stall_cycles;
    for (int i = 0; i < 6; i++) begin
      send(1'b0, 24'h000040 + 24'(i % 4), 16'h0);
      send(1'b1, 24'h000050 + 24'(i), 16'hC000 + 16'(i));
    end
    for (int i = 0; i < 6; i++) send(1'b0, 24'h000050 + 24'(i), 16'h0);
    req_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("t3_stall_seen", stall_cycles > s0, 1);
    chk("t3_last_rdata", seen_rdata, 16'hC005);

    // reset asserted during a read cycle
    send(1'b0, 24'h000010, 16'h0);
    send(1'b0, 24'h000041, 16'h0);
    req_valid = 1'b0;
    b = acc_cyc;
    wait_to(b + 1); #1;
    chk("t5_in_rd", mem_oe, 1);
    rst_n = 1'b0; #1;
    chk("t5_cs_drop", mem_cs, 0);
    chk("t5_oe_drop", mem_oe, 0);
    chk("t5_idle", idle, 1);
    r0 = rsp_count;
    repeat (2) @(negedge clk);
    chk("t5_no_rsp", rsp_count - r0, 0);
    rst_n = 1'b1; #1;
    chk("t5_idle_after", idle, 1);
    chk("t5_ready_after", req_ready, 1);
    @(negedge clk);

    // read-after-write to the same address
    send(1'b1, 24'h000060, 16'h5A5A);
    w_acc = acc_cyc;
    send(1'b0, 24'h000060, 16'h0);
    req_valid = 1'b0;
    k = acc_cyc;
    chk("t6_acc_gap", k - w_acc, ACC_GAP);
    wait_to(k + 1); chk("t6_rd_oe", mem_oe, 1);
    wait_to(k + 2); chk("t6_rsp_valid", rsp_valid, 1); chk("t6_rdata", rsp_rdata, 16'h5A5A);

    repeat (5) @(negedge clk);
    chk("end_pending", pend_q.size(), 0);
    chk("end_exp_q", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
